// File: rtl/fifo_byte_serializer.sv
// Pops 32-bit words from a synchronous FIFO and streams them out as bytes on a
// valid/ready interface, counting every word that is fully transmitted.
module fifo_byte_serializer #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_signal,
   input  logic                   fifo_empty_f,
   input  logic [DATA_WIDTH-1:0]  fifo_data_output,
   output logic                   fifo_read_enable,
   output logic [7:0]             byte_data,
   output logic                   byte_valid,
   input  logic                   byte_ready,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] word_count
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      CAPTURE = 2'd2,
      SEND    = 2'd3
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] load_word;
   logic [DATA_WIDTH-1:0] shifted;
   logic [IDX_W-1:0]      byte_idx;
   logic                  handshake;
   logic                  last_byte;

   // Word as loaded into the shift register: the first byte to send sits on top.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign load_word = fifo_data_output;
      end else begin : g_lsb_first
         // Byte-reverse so the least-significant byte goes out first.
         always_comb begin
            load_word = '0;
            for (int unsigned b = 0; b < BYTES; b++) begin
               load_word[DATA_WIDTH-1-8*b -: 8] = fifo_data_output[8*b +: 8];
            end
         end
      end
   endgenerate

   // Handshake qualification; byte_valid is high exactly when the FSM is in SEND.
   always_comb begin
      handshake = (state == SEND) && byte_ready;
      last_byte = (byte_idx == LAST_IDX);
      shifted   = shift_reg << 8;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_signal) begin
      if (!reset_signal) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; the empty flag is only looked at while idle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!fifo_empty_f) state_next = FETCH;
         FETCH:   state_next = CAPTURE;
         CAPTURE: state_next = SEND;
         SEND:    if (handshake && last_byte) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Registered outputs and datapath: strobes follow the next state so they line
   // up with the state they belong to, with no input-to-output combinational path.
   always_ff @(posedge clk or negedge reset_signal) begin
      if (!reset_signal) begin
         fifo_read_enable <= 1'b0;
         byte_valid       <= 1'b0;
         busy             <= 1'b0;
         byte_data        <= 8'h00;
         shift_reg        <= '0;
         byte_idx         <= '0;
         word_count       <= '0;
      end else begin
         fifo_read_enable <= (state_next == FETCH);
         byte_valid       <= (state_next == SEND);
         busy             <= (state_next != IDLE);
         if (state == CAPTURE) begin
            shift_reg <= load_word;
            byte_idx  <= '0;
            byte_data <= load_word[DATA_WIDTH-1 -: 8];
         end else if (handshake) begin
            if (last_byte) begin
               byte_idx   <= '0;
               byte_data  <= 8'h00;
               word_count <= word_count + COUNT_WIDTH'(1);
            end else begin
               shift_reg <= shifted;
               byte_data <= shifted[DATA_WIDTH-1 -: 8];
               byte_idx  <= byte_idx + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer: behavioural FIFO models, a cycle table for the
// single-word and backpressure cases, and sequences for burst, reset and wrap.
module tb_fifo_byte_serializer;

   logic        clk;
   logic        reset_signal;
   logic        fifo_empty_f;
   logic [31:0] fifo_data_output;
   logic        fifo_read_enable;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        busy;
   logic [15:0] word_count;

   // second instance: LSB first with a 2-bit counter to exercise wrap
   logic        empty2;
   logic [31:0] data2;
   logic        rd2;
   logic [7:0]  bdata2;
   logic        bvalid2;
   logic        ready2;
   logic        busy2;
   logic [1:0]  wc2;

   int errors = 0;
   int checks = 0;

   fifo_byte_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b1), .COUNT_WIDTH(16)) dut (
      .clk(clk), .reset_signal(reset_signal), .fifo_empty_f(fifo_empty_f),
      .fifo_data_output(fifo_data_output), .fifo_read_enable(fifo_read_enable),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .busy(busy), .word_count(word_count));

   fifo_byte_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b0), .COUNT_WIDTH(2)) dut2 (
      .clk(clk), .reset_signal(reset_signal), .fifo_empty_f(empty2),
      .fifo_data_output(data2), .fifo_read_enable(rd2),
      .byte_data(bdata2), .byte_valid(bvalid2), .byte_ready(ready2),
      .busy(busy2), .word_count(wc2));

   always #5 clk = ~clk;

   // FIFO model for the main instance
   logic [31:0] mem [0:127];
   logic [6:0]  wr_ptr = 7'd0;
   logic [6:0]  rd_ptr = 7'd0;
   int          pops = 0;
   int          underflows = 0;
   assign fifo_empty_f = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_read_enable) begin
         pops <= pops + 1;
         if (fifo_empty_f) underflows <= underflows + 1;
         else begin
            fifo_data_output <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 7'd1;
         end
      end
   end

   // FIFO model for the wrap instance
   logic [31:0] mem2 [0:7];
   logic [2:0]  wr2 = 3'd0;
   logic [2:0]  rd2p = 3'd0;
   assign empty2 = (wr2 == rd2p);

   always @(posedge clk) begin
      if (rd2 && !empty2) begin
         data2 <= mem2[rd2p];
         rd2p <= rd2p + 3'd1;
      end
   end

   // byte sinks
   logic [7:0] rx [0:255];
   int         rx_n = 0;
   logic [7:0] rx2 [0:15];
   int         rx2_n = 0;

   always @(posedge clk) begin
      if (byte_valid && byte_ready) begin
         rx[rx_n[7:0]] <= byte_data;
         rx_n <= rx_n + 1;
      end
      if (bvalid2 && ready2) begin
         rx2[rx2_n[3:0]] <= bdata2;
         rx2_n <= rx2_n + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 7'd1;
   endtask

   task automatic push_word2(input logic [31:0] w);
      mem2[wr2] = w;
      wr2 = wr2 + 3'd1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_signal = 1'b0;
      repeat (2) @(negedge clk);
      reset_signal = 1'b1;
   endtask

   typedef struct {
      logic        push;
      logic [31:0] word;
      logic        ready;
      logic        rd;
      logic        valid;
      logic [7:0]  data;
      logic        busy;
      logic [15:0] wc;
   } vec_t;

   vec_t vecs [0:20];
   int   base;
   int   pops_base;

   initial begin
      clk = 1'b0;
      reset_signal = 1'b1;
      byte_ready = 1'b0;
      ready2 = 1'b1;

      // single word, ready held high
      vecs[0]  = '{1'b1, 32'h11223344, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
      vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0};
      vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 16'd0};
      vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 16'd0};
      vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 16'd0};
      vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 16'd0};
      vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1};
      vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1};
      // same word with ready low for 5 cycles during byte 0x22
      vecs[8]  = '{1'b1, 32'h11223344, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd1};
      vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'd1};
      vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 16'd1};
      vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 16'd1};
      vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 16'd1};
      vecs[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 16'd1};
      vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 16'd1};
      vecs[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 16'd1};
      vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 16'd1};
      vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 16'd1};
      vecs[18] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 16'd1};
      vecs[19] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd2};
      vecs[20] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd2};

      // asynchronous reset state
      #3 reset_signal = 1'b0;
      #1;
      check("reset_rd",    32'(fifo_read_enable), 32'd0);
      check("reset_valid", 32'(byte_valid),       32'd0);
      check("reset_data",  32'(byte_data),        32'd0);
      check("reset_busy",  32'(busy),             32'd0);
      check("reset_wc",    32'(word_count),       32'd0);
      repeat (2) @(negedge clk);
      reset_signal = 1'b1;
      repeat (2) @(negedge clk);

      // cycle table
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         if (vecs[i].push) push_word(vecs[i].word);
         byte_ready = vecs[i].ready;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_rd", i),    32'(fifo_read_enable), 32'(vecs[i].rd));
         check($sformatf("v%0d_valid", i), 32'(byte_valid),       32'(vecs[i].valid));
         check($sformatf("v%0d_data", i),  32'(byte_data),        32'(vecs[i].data));
         check($sformatf("v%0d_busy", i),  32'(busy),             32'(vecs[i].busy));
         check($sformatf("v%0d_wc", i),    32'(word_count),       32'(vecs[i].wc));
         if (i == 7) check("single_pops", 32'(pops), 32'd1);
      end
      check("bp_pops", 32'(pops), 32'd2);

      // empty FIFO for 50 cycles: nothing moves
      byte_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         check("empty_idle", 32'({fifo_read_enable, byte_valid, busy}), 32'd0);
      end

      // burst of 32 words
      do_reset();
      base = rx_n;
      pops_base = pops;
      @(negedge clk);
      for (int i = 0; i < 32; i++) push_word(32'(i));
      byte_ready = 1'b1;
      for (int cyc = 0; cyc < 1000 && word_count != 16'd32; cyc++) begin
         @(posedge clk);
         #1;
      end
      check("burst_wc",    32'(word_count), 32'd32);
      check("burst_busy",  32'(busy), 32'd0);
      check("burst_empty", 32'(fifo_empty_f), 32'd1);
      check("burst_pops",  32'(pops - pops_base), 32'd32);
      check("burst_bytes", 32'(rx_n - base), 32'd128);
      for (int k = 0; k < 128; k++) begin
         logic [7:0] exp_b;
         exp_b = ((k % 4) == 3) ? 8'(k / 4) : 8'h00;
         check($sformatf("burst_b%0d", k), 32'(rx[8'(base + k)]), 32'(exp_b));
      end

      // reset in the middle of a word
      base = rx_n;
      @(negedge clk);
      push_word(32'hAABBCCDD);
      byte_ready = 1'b1;
      for (int cyc = 0; cyc < 50 && rx_n < base + 2; cyc++) begin
         @(posedge clk);
         #1;
      end
      check("mid_cnt", 32'(rx_n - base), 32'd2);
      reset_signal = 1'b0;
      #1;
      check("mid_rd",    32'(fifo_read_enable), 32'd0);
      check("mid_valid", 32'(byte_valid), 32'd0);
      check("mid_data",  32'(byte_data), 32'd0);
      check("mid_busy",  32'(busy), 32'd0);
      check("mid_wc",    32'(word_count), 32'd0);
      check("mid_b0",    32'(rx[8'(base)]), 32'h000000AA);
      check("mid_b1",    32'(rx[8'(base + 1)]), 32'h000000BB);
      @(negedge clk);
      reset_signal = 1'b1;
      base = rx_n;
      push_word(32'h55667788);
      for (int cyc = 0; cyc < 50 && word_count != 16'd1; cyc++) begin
         @(posedge clk);
         #1;
      end
      check("post_wc",    32'(word_count), 32'd1);
      check("post_count", 32'(rx_n - base), 32'd4);
      check("post_b0",    32'(rx[8'(base)]),     32'h55);
      check("post_b1",    32'(rx[8'(base + 1)]), 32'h66);
      check("post_b2",    32'(rx[8'(base + 2)]), 32'h77);
      check("post_b3",    32'(rx[8'(base + 3)]), 32'h88);
      check("underflows", 32'(underflows), 32'd0);

      // LSB-first instance: three words then one more wraps the 2-bit counter
      @(negedge clk);
      push_word2(32'hA3A2A1A0);
      push_word2(32'hB3B2B1B0);
      push_word2(32'hC3C2C1C0);
      for (int cyc = 0; cyc < 200 && wc2 != 2'd3; cyc++) begin
         @(posedge clk);
         #1;
      end
      check("wrap_wc3", 32'(wc2), 32'd3);
      check("lsb_b0",   32'(rx2[0]), 32'hA0);
      check("lsb_b3",   32'(rx2[3]), 32'hA3);
      @(negedge clk);
      push_word2(32'h01020304);
      repeat (20) @(posedge clk);
      #1;
      check("wrap_wc0",   32'(wc2), 32'd0);
      check("wrap_bytes", 32'(rx2_n), 32'd16);
      check("wrap_b0",    32'(rx2[12]), 32'h04);
      check("wrap_b1",    32'(rx2[13]), 32'h03);
      check("wrap_b2",    32'(rx2[14]), 32'h02);
      check("wrap_b3",    32'(rx2[15]), 32'h01);
      check("wrap_busy",  32'(busy2), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_byte_serializer.md
Name: fifo_byte_serializer

Overview:
- Downstream consumer of the 32-bit synchronous FIFO.
- Monitors the FIFO empty flag and pops one word at a time via the FIFO read strobe.
- Serializes each word into bytes on a valid/ready byte stream (e.g. toward a UART/SPI transmit stage).
- Keeps a count of fully transmitted words.

Parameters:
- DATA_WIDTH, 32: FIFO word width; must be a multiple of 8. BYTES = DATA_WIDTH/8 is derived.
- MSB_FIRST, 1: 1 = most-significant byte sent first; 0 = least-significant byte first.
- COUNT_WIDTH, 16: width of word_count.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset_signal  input  1  asynchronous, active-low reset.
- fifo_empty_f  input  1  FIFO empty flag.
- fifo_data_output  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_read_enable is sampled high.
- fifo_read_enable  output  1  FIFO pop strobe.
- byte_data  output  8  serialized byte.
- byte_valid  output  1  byte_data holds a byte for the sink.
- byte_ready  input  1  sink accepts when byte_valid && byte_ready at a rising edge.
- busy  output  1  high in any state other than IDLE.
- word_count  output  COUNT_WIDTH  words fully transmitted since reset.

Behaviour:
- Reset (reset_signal low, asynchronous; takes effect immediately):
  - state=IDLE; fifo_read_enable=0, byte_valid=0, byte_data=0, busy=0, word_count=0.
  - Shift register and byte index cleared.
  - A partially sent word is discarded, not resumed.
- FSM states: IDLE, FETCH, CAPTURE, SEND. All outputs decode from registered state; no combinational input-to-output paths.
- IDLE: if fifo_empty_f==0 -> FETCH; otherwise stay. No read strobe is ever issued while empty, so the FIFO cannot underflow.
- FETCH: fifo_read_enable=1 for exactly this one cycle; -> CAPTURE.
- CAPTURE: fifo_data_output is valid. Latch it into the shift register and set byte index=0; -> SEND.
- SEND:
  - byte_valid=1.
  - byte_data = byte[index] of the latched word. With MSB_FIRST=1, index 0 = bits [DATA_WIDTH-1 -: 8].
  - On handshake: index++.
  - On the handshake of byte BYTES-1: word_count++ (wraps modulo 2^COUNT_WIDTH), byte_valid drops next cycle, -> IDLE.
- Backpressure: while byte_valid && !byte_ready, byte_data and byte_valid hold stable. There is no timeout.
- byte_ready high while byte_valid is low is ignored.
- Latency: fifo_empty_f low in IDLE at cycle 0 -> fifo_read_enable cycle 1 -> first byte_valid cycle 3.
- Throughput: BYTES+3 cycles per word when byte_ready is held high. Words are strictly sequential; at most one FIFO pop is outstanding.
- fifo_empty_f changes during FETCH/CAPTURE/SEND are ignored; it is sampled only in IDLE.
- The block never drops or duplicates a word; FIFO order is preserved.

Test Plan:
- Single word: FIFO holds 0x11223344, byte_ready=1, MSB_FIRST=1 -> fifo_read_enable pulses 1 cycle, then bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles. First byte_valid is 3 cycles after empty falls. word_count=1. fifo_read_enable fires no more while empty.
- Backpressure: same word, byte_ready low 5 cycles during byte 0x22 -> byte_data stays 0x22 with byte_valid=1 throughout, then 0x33,0x44 follow. No extra FIFO pop.
- Burst: bench writes i=0..31 (32 words, FIFO full), then serializer drains with byte_ready=1 -> 128 bytes in order 00,00,00,00,00,00,00,01,...,00,00,00,1F. Exactly 32 read pulses. word_count=32; busy=0 and FIFO empty at end.
- Empty idle: fifo_empty_f held 1 for 50 cycles -> fifo_read_enable, byte_valid and busy stay 0.
- Reset mid-word: reset_signal low after byte 2 of 0xAABBCCDD is accepted -> outputs 0 immediately and word_count=0. After release, the next FIFO word is sent from its first byte.
- Counter wrap / LSB-first: MSB_FIRST=0, word_count preloaded via 65535 transmitted words (or forced), one more word 0x01020304 -> bytes 0x04,0x03,0x02,0x01; word_count wraps to 0.
